// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, encodings and lane helpers for the load/store
//               unit (state codes, access sizes, load codes, error codes).
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BEAT0 = 2'd1;
    localparam state_t ST_BEAT1 = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

    // True when the access spills past lane 3 into the next word.
    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        logic [2:0] bytes;
        case (size)
            SZ_B:    bytes = 3'd1;
            SZ_H:    bytes = 3'd2;
            default: bytes = 3'd4;
        endcase
        return (({1'b0, off} + bytes) > 3'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering: byte enables and write data for
//               both beats, and load extraction with sign/zero extension.
//               Honours LSU_MISALIGN_SPLIT_EN (rotated store data).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align (
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_lun,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_beat0,
    input  logic [31:0] i_beat1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);
    import lsu_pkg::*;

    logic [7:0]  w_lanes;
    logic [31:0] w_word;

    assign w_lanes = {4'b0000, size_mask(i_size)} << i_off;
    assign o_be0   = w_lanes[3:0];
    assign o_be1   = w_lanes[7:4];

`ifdef LSU_MISALIGN_SPLIT_EN
    // Rotate left by off bytes so each byte lands on its lane in either beat.
    assign o_wdata = 32'({i_st_data, i_st_data} >> (6'd32 - {1'b0, i_off, 3'b000}));
`else
    always_comb begin
        case (i_size)
            SZ_B:    o_wdata = {4{i_st_data[7:0]}};
            SZ_H:    o_wdata = {2{i_st_data[15:0]}};
            default: o_wdata = i_st_data;
        endcase
    end
`endif

    assign w_word = 32'({i_beat1, i_beat0} >> {i_off, 3'b000});

    always_comb begin
        case (i_size)
            SZ_B:    o_ld_data = i_lun ? {24'b0, w_word[7:0]}  : {{24{w_word[7]}}, w_word[7:0]};
            SZ_H:    o_ld_data = i_lun ? {16'b0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
            default: o_ld_data = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit: one request per handshake onto a word-address,
//               byte-enabled bus with ack and timeout. Optional macro
//               LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        mem_wren,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  s_length,
    input  logic [2:0]  l_length,
    input  logic        l_unsigned,
    output logic        rsp_vld,
    output logic [31:0] ld_data,
    output logic [1:0]  err,
    output logic        lsu_busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    import lsu_pkg::*;

    localparam int c_cnt_w = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = (TIMEOUT_CYC > 0) ? c_cnt_w'(TIMEOUT_CYC - 1) : '0;

    state_t             r_state, w_state_nxt;
    logic               r_we, r_lun, r_split;
    logic [31:0]        r_addr, r_st_data, r_ld_data;
    logic [1:0]         r_size, r_err;
    logic [c_cnt_w-1:0] r_cnt;

    logic        w_accept, w_illegal, w_misal, w_split, w_in_beat, w_tmo, w_last_ack;
    logic [1:0]  w_size;
    logic [3:0]  w_be0, w_be1;
    logic [31:0] w_wdata, w_ld, w_beat0, w_beat1;

    assign w_accept  = req_vld && (r_state == ST_IDLE);
    assign w_in_beat = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
    assign w_tmo     = (TIMEOUT_CYC != 0) && (r_cnt == c_tmo_last);
    assign w_last_ack = bus_ack && (((r_state == ST_BEAT0) && !r_split) || (r_state == ST_BEAT1));

    always_comb begin
        w_size    = mem_wren ? s_length : l_length[1:0];
        w_illegal = 1'b0;
        if (mem_wren) begin
            w_illegal = (s_length == 2'b11);
        end else begin
            case (l_length)
                LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: w_illegal = 1'b0;
                default:                             w_illegal = 1'b1;
            endcase
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] r_beat0;

    assign w_misal = 1'b0;
    assign w_split = crosses_word(w_size, addr[1:0]);
    // Beat 0 data is live on the bus unless we are already waiting on beat 1.
    assign w_beat0 = (r_state == ST_BEAT1) ? r_beat0 : bus_rdata;
    assign w_beat1 = bus_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat0 <= '0;
        end else if ((r_state == ST_BEAT0) && bus_ack && !r_we) begin
            r_beat0 <= bus_rdata;
        end
    end
`else
    assign w_misal = misaligned(w_size, addr[1:0]);
    assign w_split = 1'b0;
    assign w_beat0 = bus_rdata;
    assign w_beat1 = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = (w_illegal || w_misal) ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                if (bus_ack)    w_state_nxt = r_split ? ST_BEAT1 : ST_RESP;
                else if (w_tmo) w_state_nxt = ST_RESP;
            end
            ST_BEAT1: begin
                if (bus_ack || w_tmo) w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_lun     <= 1'b0;
            r_split   <= 1'b0;
            r_addr    <= '0;
            r_st_data <= '0;
            r_size    <= '0;
            r_err     <= ERR_OK;
            r_cnt     <= '0;
            r_ld_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we      <= mem_wren;
                r_lun     <= l_unsigned;
                r_addr    <= addr;
                r_st_data <= st_data;
                r_size    <= w_size;
                r_split   <= w_split;
                r_err     <= w_illegal ? ERR_SIZE : (w_misal ? ERR_MISALIGN : ERR_OK);
            end
            // Wait counter restarts on every beat entry (ack) and outside beats.
            if (w_in_beat && !bus_ack) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (w_tmo) r_err <= ERR_TIMEOUT;
            end else begin
                r_cnt <= '0;
            end
            if (w_last_ack && !r_we) r_ld_data <= w_ld;
        end
    end

    lsu_align u_align (
        .i_off     (r_addr[1:0]),
        .i_size    (r_size),
        .i_lun     (r_lun),
        .i_st_data (r_st_data),
        .i_beat0   (w_beat0),
        .i_beat1   (w_beat1),
        .o_be0     (w_be0),
        .o_be1     (w_be1),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld)
    );

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (w_in_beat) begin
            bus_req   = 1'b1;
            bus_we    = r_we;
            bus_wdata = w_wdata;
            bus_addr  = {r_addr[31:2], 2'b00} + ((r_state == ST_BEAT1) ? 32'd4 : 32'd0);
            bus_be    = (r_state == ST_BEAT1) ? w_be1 : w_be0;
        end
    end

    assign req_rdy  = (r_state == ST_IDLE);
    assign lsu_busy = (r_state != ST_IDLE);
    assign rsp_vld  = (r_state == ST_RESP);
    assign err      = rsp_vld ? r_err : ERR_OK;
    assign ld_data  = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu against a byte-level reference
//               model with a behavioural bus memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;
    localparam int TMO = 16;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_vld = 0, req_rdy, mem_wren = 0, l_unsigned = 0;
    logic [31:0] addr = 0, st_data = 0, ld_data, bus_addr, bus_wdata, bus_rdata = 0;
    logic [1:0]  s_length = 0, err;
    logic [2:0]  l_length = 0;
    logic        rsp_vld, lsu_busy, bus_req, bus_we, bus_ack = 0;
    logic [3:0]  bus_be;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_ld = 0;
    bit [31:0] mem [bit [31:0]];

    typedef struct {
        bit rdy; bit seen; int lat; logic [1:0] err; logic [31:0] ld; int nb; int reqcyc; bit busy_bad;
        logic [31:0] ba0, ba1, wd0, wd1; logic [3:0] be0, be1; logic we0, we1;
    } obs_t;

    typedef struct {
        logic [1:0] err; logic [31:0] ld; int nb; int reqcyc; int lat;
        logic [31:0] ba0, ba1, wd0, wd1; logic [3:0] be0, be1;
    } exp_t;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .mem_wren(mem_wren),
        .addr(addr), .st_data(st_data), .s_length(s_length), .l_length(l_length),
        .l_unsigned(l_unsigned), .rsp_vld(rsp_vld), .ld_data(ld_data), .err(err),
        .lsu_busy(lsu_busy), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return wa * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] b);
        logic [31:0] w;
        w = rd_word({b[31:2], 2'b00}) >> (8 * b[1:0]);
        return w[7:0];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Reference: the access is a run of n bytes starting at a; each byte belongs to its own word.
    function automatic exp_t model(input bit we, input logic [31:0] a, input logic [31:0] sd,
                                   input logic [1:0] sl, input logic [2:0] ll, input bit lun, input int dly);
        exp_t e; int n; int off; int nbt; logic [31:0] b, v;
        e = '{default: 0};
        e.ld = exp_ld;
        if (we) n = (sl == 0) ? 1 : (sl == 1) ? 2 : (sl == 2) ? 4 : 0;
        else    n = (ll == 0 || ll == 4) ? 1 : (ll == 1 || ll == 5) ? 2 : (ll == 2) ? 4 : 0;
        off = int'(a[1:0]);
        if (n == 0) begin e.err = 2'b11; e.lat = 1; return e; end
        if (!SPLIT && (off % n) != 0) begin e.err = 2'b01; e.lat = 1; return e; end
        nbt = (off + n > 4) ? 2 : 1;
        e.ba0 = {a[31:2], 2'b00};
        e.ba1 = e.ba0 + 32'd4;
        v = 0;
        for (int i = 0; i < n; i++) begin
            b = a + i;
            if (b[31:2] == a[31:2]) begin e.be0[b[1:0]] = 1'b1; e.wd0[8*b[1:0] +: 8] = sd[8*i +: 8]; end
            else                    begin e.be1[b[1:0]] = 1'b1; e.wd1[8*b[1:0] +: 8] = sd[8*i +: 8]; end
            v[8*i +: 8] = rd_byte(b);
        end
        if (dly >= TMO) begin e.err = 2'b10; e.nb = 1; e.reqcyc = TMO; e.lat = TMO + 1; return e; end
        e.nb = nbt; e.reqcyc = nbt * (dly + 1); e.lat = e.reqcyc + 1;
        if (!we) begin
            if (n == 1 && !lun) v = {{24{v[7]}}, v[7:0]};
            if (n == 2 && !lun) v = {{16{v[15]}}, v[15:0]};
            e.ld = v;
        end
        return e;
    endfunction

    // Drives one request and plays the bus slave; acks each beat after dly wait cycles.
    task automatic run_req(input bit we, input logic [31:0] a, input logic [31:0] sd, input logic [1:0] sl,
                           input logic [2:0] ll, input bit lun, input int dly, output obs_t o);
        int w, bi; bit acked; logic [31:0] wv;
        o = '{default: 0};
        w = 0; bi = 0; acked = 0;
        @(negedge clk);
        o.rdy = req_rdy;
        req_vld = 1; mem_wren = we; addr = a; st_data = sd; s_length = sl; l_length = ll; l_unsigned = lun;
        @(posedge clk);
        #1;
        req_vld = 0; mem_wren = $urandom_range(0, 1); addr = $urandom; st_data = $urandom;
        s_length = 2'($urandom); l_length = 3'($urandom); l_unsigned = $urandom_range(0, 1);
        for (int cyc = 1; cyc <= 60 && !o.seen; cyc++) begin
            @(negedge clk);
            bus_ack = 0;
            bus_rdata = $urandom;
            if (!lsu_busy) o.busy_bad = 1;
            if (bus_req) begin
                if (acked) begin bi++; w = 0; acked = 0; end
                o.nb = bi + 1;
                o.reqcyc++;
                if (bi == 0) begin o.ba0 = bus_addr; o.be0 = bus_be; o.wd0 = bus_wdata; o.we0 = bus_we; end
                else         begin o.ba1 = bus_addr; o.be1 = bus_be; o.wd1 = bus_wdata; o.we1 = bus_we; end
                if (w == dly) begin
                    bus_ack = 1; acked = 1;
                    bus_rdata = rd_word(bus_addr);
                    if (bus_we) begin
                        wv = rd_word(bus_addr);
                        for (int k = 0; k < 4; k++) if (bus_be[k]) wv[8*k +: 8] = bus_wdata[8*k +: 8];
                        mem[bus_addr] = wv;
                    end
                end else begin
                    w++;
                end
            end else begin
                bus_ack = $urandom_range(0, 1);  // stray ack outside a beat
            end
            if (rsp_vld) begin o.seen = 1; o.lat = cyc; o.err = err; o.ld = ld_data; end
        end
        @(posedge clk);
        #1 bus_ack = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", req_rdy); end
        n_cmp++; if ({rsp_vld, lsu_busy, bus_req, bus_we} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl got=%b exp=0000", {rsp_vld, lsu_busy, bus_req, bus_we}); end
        n_cmp++; if ({ld_data, err, bus_addr, bus_be, bus_wdata} !== '0) begin n_bad++; $display("FAIL reset_data ld=%h err=%b ba=%h be=%b wd=%h exp=0", ld_data, err, bus_addr, bus_be, bus_wdata); end
        rst_n = 1;
        exp_ld = 0;
    endtask

    task automatic test_sb;
        obs_t o; exp_t e;
        e = model(1, 32'h1003, 32'h0000_00A5, 2'b00, 3'b000, 0, 0);
        run_req(1, 32'h1003, 32'h0000_00A5, 2'b00, 3'b000, 0, 0, o);
        n_cmp++; if (o.ba0 !== 32'h1000 || o.be0 !== 4'b1000) begin n_bad++; $display("FAIL sb_bus ba=%h be=%b exp=00001000/1000", o.ba0, o.be0); end
        n_cmp++; if (o.lat !== 2 || o.err !== 2'b00) begin n_bad++; $display("FAIL sb_rsp lat=%0d err=%b exp=2/00", o.lat, o.err); end
`ifndef LSU_MISALIGN_SPLIT_EN
        n_cmp++; if (o.wd0 !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", o.wd0); end
`endif
        n_cmp++; if ((o.wd0 & 32'hFF00_0000) !== (e.wd0 & 32'hFF00_0000)) begin n_bad++; $display("FAIL sb_lane got=%h exp=%h", o.wd0, e.wd0); end
        exp_ld = e.ld;
    endtask

    task automatic test_lb_lbu;
        obs_t o; exp_t e;
        mem[32'h2000] = 32'h0000_8000;
        e = model(0, 32'h2001, 0, 2'b00, 3'b000, 0, 1);
        run_req(0, 32'h2001, 0, 2'b00, 3'b000, 0, 1, o);
        n_cmp++; if (o.ld !== 32'hFFFF_FF80 || e.ld !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb got=%h exp=ffffff80", o.ld); end
        exp_ld = e.ld;
        e = model(0, 32'h2001, 0, 2'b00, 3'b100, 1, 2);
        run_req(0, 32'h2001, 0, 2'b00, 3'b100, 1, 2, o);
        n_cmp++; if (o.ld !== 32'h0000_0080 || o.lat !== e.lat) begin n_bad++; $display("FAIL lbu got=%h lat=%0d exp=00000080/%0d", o.ld, o.lat, e.lat); end
        exp_ld = e.ld;
    endtask

    task automatic test_misaligned;
        obs_t o; exp_t e;
        mem[32'h3000] = 32'h4433_2211;
        mem[32'h3004] = 32'h8877_6655;
        e = model(0, 32'h3002, 0, 2'b00, 3'b010, 0, 0);
        run_req(0, 32'h3002, 0, 2'b00, 3'b010, 0, 0, o);
`ifdef LSU_MISALIGN_SPLIT_EN
        n_cmp++; if (o.ld !== 32'h6655_4433 || o.nb !== 2 || o.err !== 2'b00) begin n_bad++; $display("FAIL lw_split ld=%h nb=%0d err=%b exp=66554433/2/00", o.ld, o.nb, o.err); end
        n_cmp++; if (o.ba1 !== 32'h3004 || o.be1 !== 4'b0011 || o.be0 !== 4'b1100) begin n_bad++; $display("FAIL lw_split_bus ba1=%h be0=%b be1=%b", o.ba1, o.be0, o.be1); end
`else
        n_cmp++; if (o.err !== 2'b01 || o.reqcyc !== 0 || o.lat !== 1) begin n_bad++; $display("FAIL lw_misalign err=%b reqcyc=%0d lat=%0d exp=01/0/1", o.err, o.reqcyc, o.lat); end
`endif
        n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL lw_ld got=%h exp=%h", o.ld, e.ld); end
        exp_ld = e.ld;
    endtask

    task automatic test_timeout;
        obs_t o;
        run_req(0, 32'h5000, 0, 2'b00, 3'b010, 0, 1000, o);
        n_cmp++; if (o.reqcyc !== TMO || o.err !== 2'b10 || o.lat !== TMO + 1) begin n_bad++; $display("FAIL timeout reqcyc=%0d err=%b lat=%0d exp=%0d/10/%0d", o.reqcyc, o.err, o.lat, TMO, TMO + 1); end
        n_cmp++; if (o.ld !== exp_ld) begin n_bad++; $display("FAIL timeout_ld got=%h exp=%h", o.ld, exp_ld); end
    endtask

    task automatic test_illegal;
        obs_t o;
        run_req(1, 32'h6000, 32'h1111_2222, 2'b11, 3'b000, 0, 0, o);
        n_cmp++; if (o.err !== 2'b11 || o.reqcyc !== 0) begin n_bad++; $display("FAIL ill_store err=%b reqcyc=%0d exp=11/0", o.err, o.reqcyc); end
        run_req(0, 32'h6000, 0, 2'b00, 3'b011, 0, 0, o);
        n_cmp++; if (o.err !== 2'b11 || o.reqcyc !== 0 || o.ld !== exp_ld) begin n_bad++; $display("FAIL ill_load err=%b reqcyc=%0d ld=%h", o.err, o.reqcyc, o.ld); end
    endtask

    task automatic test_reset_mid;
        obs_t o; exp_t e; bit seen;
        @(negedge clk);
        req_vld = 1; mem_wren = 0; addr = 32'h4000; l_length = 3'b010; l_unsigned = 0;
        @(posedge clk);
        #1 req_vld = 0;
        @(negedge clk);
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req got=%b exp=1", bus_req); end
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_cmp++; if (bus_req !== 1'b0 || rsp_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_drop req=%b rsp=%b exp=0/0", bus_req, rsp_vld); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_ld = 0;
        seen = 0;
        repeat (4) begin @(negedge clk); if (rsp_vld) seen = 1; end
        n_cmp++; if (seen !== 1'b0 || req_rdy !== 1'b1 || ld_data !== 32'h0) begin n_bad++; $display("FAIL rmid_after rsp=%b rdy=%b ld=%h", seen, req_rdy, ld_data); end
        e = model(0, 32'h4000, 0, 2'b00, 3'b010, 0, 3);
        run_req(0, 32'h4000, 0, 2'b00, 3'b010, 0, 3, o);
        n_cmp++; if (o.err !== 2'b00 || o.ld !== e.ld || o.lat !== e.lat) begin n_bad++; $display("FAIL rmid_next err=%b ld=%h lat=%0d exp=00/%h/%0d", o.err, o.ld, o.lat, e.ld, e.lat); end
        exp_ld = e.ld;
    endtask

    task automatic test_random;
        obs_t o; exp_t e; bit we, lun; logic [31:0] a, sd; logic [1:0] sl; logic [2:0] ll; int dly;
        logic [2:0] codes [6];
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        for (int it = 0; it < 40; it++) begin
            we = $urandom_range(0, 1);
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = {30'h3FFF_FFFF, a[1:0]};
            sd = $urandom;
            sl = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ll = codes[$urandom_range(0, 5)];
            lun = ll[2];
            dly = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            e = model(we, a, sd, sl, ll, lun, dly);
            run_req(we, a, sd, sl, ll, lun, dly, o);
            n_cmp++; if (!o.rdy || !o.seen || o.busy_bad) begin n_bad++; $display("FAIL rnd%0d_hs rdy=%b seen=%b busy_bad=%b", it, o.rdy, o.seen, o.busy_bad); end
            n_cmp++; if (o.err !== e.err || o.lat !== e.lat) begin n_bad++; $display("FAIL rnd%0d_rsp err=%b lat=%0d exp=%b/%0d a=%h", it, o.err, o.lat, e.err, e.lat, a); end
            n_cmp++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL rnd%0d_ld got=%h exp=%h a=%h ll=%b", it, o.ld, e.ld, a, ll); end
            n_cmp++; if (o.nb !== e.nb || o.reqcyc !== e.reqcyc) begin n_bad++; $display("FAIL rnd%0d_beats nb=%0d cyc=%0d exp=%0d/%0d", it, o.nb, o.reqcyc, e.nb, e.reqcyc); end
            if (e.nb >= 1) begin
                n_cmp++;
                if (o.ba0 !== e.ba0 || o.be0 !== e.be0 || o.we0 !== we ||
                    (we && ((o.wd0 & lane_mask(e.be0)) !== (e.wd0 & lane_mask(e.be0))))) begin
                    n_bad++; $display("FAIL rnd%0d_beat0 ba=%h be=%b wd=%h we=%b exp=%h/%b/%h/%b", it, o.ba0, o.be0, o.wd0, o.we0, e.ba0, e.be0, e.wd0, we);
                end
            end
            if (e.nb == 2) begin
                n_cmp++;
                if (o.ba1 !== e.ba1 || o.be1 !== e.be1 || o.we1 !== we ||
                    (we && ((o.wd1 & lane_mask(e.be1)) !== (e.wd1 & lane_mask(e.be1))))) begin
                    n_bad++; $display("FAIL rnd%0d_beat1 ba=%h be=%b wd=%h exp=%h/%b/%h", it, o.ba1, o.be1, o.wd1, e.ba1, e.be1, e.wd1);
                end
            end
            exp_ld = e.ld;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sb();
        test_lb_lbu();
        test_misaligned();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit: the consumer of the decoder's memory-control outputs (mem_wren, s_length, l_length, l_unsigned).
- Takes one memory request per handshake from the core datapath and drives a word-addressed, byte-enabled data-memory bus with an ack handshake.
- Returns sign- or zero-extended load data, or an error code.
- Holds the core via lsu_busy while an access is outstanding.

Parameters:
- TIMEOUT_CYC, 16: cycles to wait for bus_ack before aborting; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- req_vld  in  1  request valid
- req_rdy  out  1  unit can accept a request (high only in IDLE)
- mem_wren  in  1  1 = store, 0 = load
- addr  in  32  byte address (ALU result)
- st_data  in  32  store data, rs2
- s_length  in  2  00 SB, 01 SH, 10 SW, 11 illegal
- l_length  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- l_unsigned  in  1  zero-extend load
- rsp_vld  out  1  one-cycle response pulse
- ld_data  out  32  extended load data; held until the next rsp_vld
- err  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal size; valid with rsp_vld
- lsu_busy  out  1  high from request accept through the response cycle
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address; bits [1:0] are always 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered write data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle acknowledge

Behaviour:
- Reset (asynchronous): state = IDLE. All outputs 0 except req_rdy = 1. ld_data = 0, counters = 0. Asserting reset mid-access drops bus_req immediately; no response is issued for that access.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - On req_vld & req_rdy, latch mem_wren, addr, st_data, the size fields and l_unsigned.
  - Size = s_length for stores, l_length[1:0] for loads. off = addr[1:0].
  - Illegal size -> RESP with err = 11, no bus access.
  - Misaligned (half with off[0] = 1, word with off != 0) -> RESP with err = 01, no bus access.
  - Otherwise -> BEAT0.
- BEAT0 / BEAT1:
  - bus_req = 1, bus_we = latched mem_wren; addr/be/wdata stay stable until bus_ack.
  - On bus_ack: for a load, capture bus_rdata into beat register 0 or 1. Then go BEAT1 if a split is pending, else RESP.
  - A bus_ack arriving in any other state is ignored.
- Timeout: the wait counter resets on entry to each beat. If it reaches TIMEOUT_CYC without ack -> RESP with err = 10 and bus_req deasserted; ld_data is not updated.
- RESP:
  - rsp_vld = 1 for exactly one cycle, with err.
  - For a successful load, ld_data updates in the same cycle.
  - Next state is IDLE. The earliest next accept is the cycle after RESP.
- Latency, aligned access with zero-wait ack:
  - accept at cycle N;
  - bus_req at N+1, ack at N+1;
  - rsp_vld at N+2.
- Store lane steering:
  - SB: be = 0001 << off; wdata = {4{st_data[7:0]}}.
  - SH: be = 0011 << off; wdata = {2{st_data[15:0]}}.
  - SW: be = 1111; wdata = st_data.
- Load extraction:
  - Read word = beat0 data, shifted right by off*8.
  - Byte/half is sign-extended, or zero-extended when l_unsigned = 1.
  - LW is passed through unchanged.
- bus_addr = {addr[31:2], 2'b00} for BEAT0, and that word address + 4 for BEAT1. Address arithmetic wraps modulo 2^32, so 0xFFFFFFFC + 4 = 0x00000000.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses never raise err 01.
  - An access whose bytes stay inside one word is a single beat with shifted be.
  - An access with off + bytes > 4 splits into two beats:
    - BEAT0: be = lanes off..3;
    - BEAT1: next word, be = remaining low lanes;
    - store data is rotated left by off*8 for both beats.
  - Load result = ({beat1, beat0} >> off*8)[31:0], then extended.
  - A timeout on either beat aborts the access with err 10. Any BEAT0 store already performed is not undone.
- Undefined: misaligned -> err 01 with no bus activity; the BEAT1 state and its register are not synthesized.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - size encodings (SZ_B/SZ_H/SZ_W);
  - l_length codes;
  - err codes (ERR_OK/ERR_MISALIGN/ERR_TIMEOUT/ERR_SIZE).
- Sub-module lsu_align (combinational): off, size, st_data -> be/wdata for both beats; beat data, off, size, l_unsigned -> ld_data.
- The FSM, counters and registers stay in lsu.

Test Plan:
- SB: addr = 0x1003, st_data = 0xA5 -> bus_addr 0x1000, be 1000, wdata 0xA5A5A5A5, rsp_vld at N+2, err 00.
- LB vs LBU: addr = 0x2001, bus_rdata 0x0000_8000 -> LB ld_data 0xFFFFFF80; LBU ld_data 0x00000080.
- LW at 0x3002:
  - without the macro -> rsp_vld with err 01 and no bus_req;
  - with the macro and bus words 0x44332211 at 0x3000, 0x88776655 at 0x3004 -> ld_data 0x66554433, two beats observed.
- Bus never acks, TIMEOUT_CYC = 16 -> bus_req high 16 cycles, then rsp_vld with err 10; ld_data unchanged.
- s_length = 11 store -> err 11, no bus_req; l_length = 011 load -> err 11.
- Reset pulled low during BEAT0 with 3-cycle ack delay -> bus_req low immediately, no rsp_vld, req_rdy = 1 after release; the next request completes normally.
